// File: rtl/maclaurin_series_unit_pkg.sv
// Shared encodings and constants for the Maclaurin series unit.
// Coefficients are 1/(m*(m+1)) in Q2.FRAC, rounded half-up.
package maclaurin_pkg;

    localparam logic [1:0] SIN  = 2'b00;
    localparam logic [1:0] COS  = 2'b01;
    localparam logic [1:0] SINH = 2'b10;
    localparam logic [1:0] COSH = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SQ,
        MULX,
        MULC,
        ACC,
        DONE
    } state_e;

    function automatic longint coef_val(input int m, input int frac);
        longint d;
        longint one;
        d   = longint'(m) * longint'(m + 1);
        one = longint'(1) <<< frac;
        if (d == 64'sd0) begin
            return 64'sd0;
        end
        return (64'sd2 * one + d) / (64'sd2 * d);
    endfunction

endpackage

// File: rtl/maclaurin_series_unit_fx_mul.sv
// Signed Q2.FRAC multiply: full product, round half-up, shift, saturate.
module fx_mul #(
    parameter int W    = 16,
    parameter int FRAC = W - 2
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] p_o,
    output logic                ovf_o
);

    localparam int PW = 2 * W + 1;
    localparam logic signed [PW-1:0] RND  = PW'(64'sd1 <<< (FRAC - 1));
    localparam logic signed [PW-1:0] MAXV = PW'((64'sd1 <<< (W - 1)) - 64'sd1);
    localparam logic signed [PW-1:0] MINV = PW'(-(64'sd1 <<< (W - 1)));

    logic signed [2*W-1:0] full;
    logic signed [PW-1:0]  rnd;
    logic signed [PW-1:0]  shf;

    always_comb begin
        full  = (2*W)'(a_i) * (2*W)'(b_i);
        rnd   = PW'(full) + RND;
        shf   = rnd >>> FRAC;
        ovf_o = 1'b0;
        p_o   = shf[W-1:0];
        if (shf > MAXV) begin
            p_o   = MAXV[W-1:0];
            ovf_o = 1'b1;
        end else if (shf < MINV) begin
            p_o   = MINV[W-1:0];
            ovf_o = 1'b1;
        end
    end

endmodule

// File: rtl/maclaurin_series_unit.sv
// Sin/cos/sinh/cosh by Maclaurin series on one shared fixed-point multiplier.
// Term recurrence: term *= x^2, then term *= 1/(m*(m+1)).
module maclaurin_series_unit
    import maclaurin_pkg::*;
#(
    parameter int W      = 16,
    parameter int NTERMS = 4,
    parameter int ACCW   = W + 2
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [W-1:0] xBus,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] rBus,
    output logic         sat
);

    localparam int FRAC = W - 2;
    localparam int KW   = 3;
    localparam int NC   = 2 * NTERMS + 1;
    localparam int MW   = $clog2(NC);

    localparam logic [KW-1:0]         KLAST = KW'(NTERMS - 2);
    localparam logic signed [W-1:0]   ONE   = W'(64'sd1 <<< FRAC);
    localparam logic signed [ACCW:0]  AMAX  = (ACCW+1)'((64'sd1 <<< (ACCW - 1)) - 64'sd1);
    localparam logic signed [ACCW:0]  AMIN  = (ACCW+1)'(-(64'sd1 <<< (ACCW - 1)));
    localparam logic signed [ACCW-1:0] WMAX = ACCW'((64'sd1 <<< (W - 1)) - 64'sd1);
    localparam logic signed [ACCW-1:0] WMIN = ACCW'(-(64'sd1 <<< (W - 1)));

    state_e state_q, state_d;

    logic signed [W-1:0]    x_q;
    logic signed [W-1:0]    x2_q;
    logic signed [W-1:0]    term_q;
    logic signed [W-1:0]    rBus_q;
    logic signed [ACCW-1:0] acc_q;
    logic [KW-1:0]          k_q;
    logic                   odd_q;
    logic                   hyp_q;
    logic                   satF_q;
    logic                   sat_q;

    logic signed [W-1:0]    coefTab [NC];
    logic [MW-1:0]          m;
    logic signed [W-1:0]    mulA;
    logic signed [W-1:0]    mulB;
    logic signed [W-1:0]    mulP;
    logic                   mulOvf;

    logic                   sub;
    logic signed [ACCW:0]   sum;
    logic signed [ACCW-1:0] accN;
    logic signed [W-1:0]    resN;
    logic                   accClip;
    logic                   wClip;

    for (genvar g = 0; g < NC; g++) begin : g_coef
        assign coefTab[g] = W'(coef_val(g, FRAC));
    end

    assign m = MW'({k_q, 1'b0}) + MW'(1) + MW'(odd_q);

    always_comb begin
        mulA = term_q;
        mulB = x2_q;
        case (state_q)
            SQ: begin
                mulA = x_q;
                mulB = x_q;
            end
            MULC: mulB = coefTab[m];
            default: ;
        endcase
    end

    fx_mul #(
        .W    (W),
        .FRAC (FRAC)
    ) u_mul (
        .a_i   (mulA),
        .b_i   (mulB),
        .p_o   (mulP),
        .ovf_o (mulOvf)
    );

    // Trig series alternate sign starting with subtraction; hyperbolic never subtract.
    always_comb begin
        sub     = !hyp_q && !k_q[0];
        sum     = sub ? ((ACCW+1)'(acc_q) - (ACCW+1)'(term_q))
                      : ((ACCW+1)'(acc_q) + (ACCW+1)'(term_q));
        accClip = 1'b0;
        accN    = sum[ACCW-1:0];
        if (sum > AMAX) begin
            accN    = AMAX[ACCW-1:0];
            accClip = 1'b1;
        end else if (sum < AMIN) begin
            accN    = AMIN[ACCW-1:0];
            accClip = 1'b1;
        end
        wClip = 1'b0;
        resN  = accN[W-1:0];
        if (accN > WMAX) begin
            resN  = WMAX[W-1:0];
            wClip = 1'b1;
        end else if (accN < WMIN) begin
            resN  = WMIN[W-1:0];
            wClip = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) state_d = LOAD;
            end
            LOAD: state_d = SQ;
            SQ:   state_d = MULX;
            MULX: state_d = MULC;
            MULC: state_d = ACC;
            ACC:  state_d = (k_q == KLAST) ? DONE : MULX;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            x_q    <= '0;
            x2_q   <= '0;
            term_q <= '0;
            acc_q  <= '0;
            k_q    <= '0;
            odd_q  <= 1'b0;
            hyp_q  <= 1'b0;
            satF_q <= 1'b0;
            rBus_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q   <= xBus;
                        odd_q <= (mode == SIN) || (mode == SINH);
                        hyp_q <= (mode == SINH) || (mode == COSH);
                    end
                end
                LOAD: begin
                    term_q <= odd_q ? x_q : ONE;
                    acc_q  <= odd_q ? ACCW'(x_q) : ACCW'(ONE);
                    k_q    <= '0;
                    satF_q <= 1'b0;
                end
                SQ: begin
                    x2_q   <= mulP;
                    satF_q <= satF_q | mulOvf;
                end
                MULX, MULC: begin
                    term_q <= mulP;
                    satF_q <= satF_q | mulOvf;
                end
                ACC: begin
                    acc_q  <= accN;
                    k_q    <= k_q + KW'(1);
                    satF_q <= satF_q | accClip;
                    if (k_q == KLAST) begin
                        rBus_q <= resN;
                        sat_q  <= satF_q | accClip | wClip;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rBus = rBus_q;
    assign sat  = sat_q;

endmodule

// File: tb/tb_maclaurin_series_unit.sv
// Randomized bench for maclaurin_series_unit against a series-level model.
`timescale 1ns/1ps
module tb_maclaurin_series_unit;

    localparam int W      = 16;
    localparam int NTERMS = 4;
    localparam int FRAC   = W - 2;
    localparam int ACCW   = W + 2;
    localparam int LAT    = 3 + 3 * (NTERMS - 1);

    logic         clk   = 1'b0;
    logic         rstN  = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   mode  = 2'b00;
    logic [W-1:0] xBus  = '0;
    logic         ready;
    logic         done;
    logic [W-1:0] rBus;
    logic         sat;

    typedef struct {
        logic [W-1:0] r;
        bit           s;
        int           c;
    } exp_t;

    exp_t         q[$];
    exp_t         ce;
    int           vecs  = 0;
    int           errs  = 0;
    int           cyc   = 0;
    int           ndone = 0;
    logic [W-1:0] lastR = '0;
    bit           lastS = 1'b0;
    bit           msat;

    maclaurin_series_unit #(
        .W      (W),
        .NTERMS (NTERMS),
        .ACCW   (ACCW)
    ) dut (
        .clk   (clk),
        .rstN  (rstN),
        .start (start),
        .mode  (mode),
        .xBus  (xBus),
        .ready (ready),
        .done  (done),
        .rBus  (rBus),
        .sat   (sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint clampv(input longint v, input int bits);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bits - 1));
        if (v > hi) begin
            msat = 1'b1;
            return hi;
        end
        if (v < lo) begin
            msat = 1'b1;
            return lo;
        end
        return v;
    endfunction

    function automatic longint fxm(input longint a, input longint b);
        return clampv((a * b + (64'sd1 <<< (FRAC - 1))) >>> FRAC, W);
    endfunction

    function automatic longint coef(input int m);
        return longint'($rtoi(real'(1 << FRAC) / real'(m * (m + 1)) + 0.5));
    endfunction

    // Series value: sum of x^(2k+odd)/(2k+odd)! with fixed-point rounding per step.
    task automatic model(input logic [1:0] md, input logic [W-1:0] xb,
                         output logic [W-1:0] r, output bit s);
        longint x, x2, term, acc, t1;
        bit odd, hyp;
        msat = 1'b0;
        x    = longint'($signed(xb));
        odd  = (md == 2'b00) || (md == 2'b10);
        hyp  = md[1];
        term = odd ? x : (64'sd1 <<< FRAC);
        acc  = term;
        x2   = fxm(x, x);
        for (int k = 0; k < NTERMS - 1; k++) begin
            t1   = fxm(term, x2);
            term = fxm(t1, coef(2 * k + 1 + int'(odd)));
            acc  = (!hyp && (k % 2 == 0)) ? acc - term : acc + term;
            acc  = clampv(acc, ACCW);
        end
        r = W'(clampv(acc, W));
        s = msat;
    endtask

    always @(negedge clk) begin
        if (rstN) begin
            vecs++;
            if (ready !== ((q.size() == 0) && !done)) begin
                errs++;
                $display("FAIL ready: got %b want %b at cycle %0d",
                         ready, (q.size() == 0) && !done, cyc);
            end
            if (done === 1'b1) begin
                ndone++;
                if (q.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_done: got done=1 want 0 at cycle %0d", cyc);
                end else begin
                    ce = q.pop_front();
                    vecs += 3;
                    if (rBus !== ce.r) begin
                        errs++;
                        $display("FAIL result: got %h want %h", rBus, ce.r);
                    end
                    if (sat !== ce.s) begin
                        errs++;
                        $display("FAIL sat: got %b want %b", sat, ce.s);
                    end
                    if (cyc - ce.c + 1 != LAT) begin
                        errs++;
                        $display("FAIL latency: got %0d want %0d", cyc - ce.c + 1, LAT);
                    end
                    lastR = rBus;
                    lastS = sat;
                end
            end
        end
    end

    task automatic near(input string nm, input logic [W-1:0] act,
                        input logic [W-1:0] req, input int tol);
        int d;
        d = int'($signed(act)) - int'($signed(req));
        vecs++;
        if (d > tol || d < -tol) begin
            errs++;
            $display("FAIL %s: got %h want %h +-%0d", nm, act, req, tol);
        end
    endtask

    task automatic bitchk(input string nm, input logic act, input logic req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %b want %b", nm, act, req);
        end
    endtask

    task automatic issue(input logic [1:0] md, input logic [W-1:0] xb);
        exp_t e;
        int t;
        t = 0;
        @(negedge clk);
        while (ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (ready !== 1'b1) begin
            errs++;
            $display("FAIL ready_timeout: got %b want 1", ready);
        end
        start = 1'b1;
        mode  = md;
        xBus  = xb;
        @(posedge clk);
        #1;
        model(md, xb, e.r, e.s);
        e.c = cyc;
        q.push_back(e);
        start = 1'b0;
        mode  = 2'($urandom);
        xBus  = W'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    logic [W-1:0] mr;
    bit           ms;
    int           n0;
    int           c0;
    logic [W-1:0] edges [5] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h4000, 16'hC000};

    initial begin
        #12;
        bitchk("rst_ready", ready, 1'b1);
        bitchk("rst_done", done, 1'b0);
        near("rst_rbus", rBus, 16'h0000, 0);
        bitchk("rst_sat", sat, 1'b0);
        @(negedge clk);
        rstN = 1'b1;

        model(2'b00, 16'h2000, mr, ms);
        near("model_sin_half", mr, 16'h1EAF, 2);
        model(2'b01, 16'h0000, mr, ms);
        near("model_cos_zero", mr, 16'h4000, 0);
        model(2'b10, 16'h4000, mr, ms);
        near("model_sinh_one", mr, 16'h4B37, 2);
        model(2'b00, 16'hE000, mr, ms);
        near("model_sin_mhalf", mr, 16'hE151, 2);
        model(2'b11, 16'h8000, mr, ms);
        near("model_cosh_m2", mr, 16'h7FFF, 0);
        bitchk("model_cosh_m2_sat", ms, 1'b1);

        issue(2'b00, 16'h2000);
        drain();
        near("sin_half", lastR, 16'h1EAF, 2);
        bitchk("sin_half_sat", lastS, 1'b0);

        issue(2'b01, 16'h0000);
        drain();
        near("cos_zero", lastR, 16'h4000, 0);
        bitchk("cos_zero_sat", lastS, 1'b0);

        issue(2'b10, 16'h4000);
        drain();
        near("sinh_one", lastR, 16'h4B37, 2);
        issue(2'b00, 16'hE000);
        drain();
        near("sin_mhalf", lastR, 16'hE151, 2);

        issue(2'b11, 16'h8000);
        drain();
        near("cosh_m2", lastR, 16'h7FFF, 0);
        bitchk("cosh_m2_sat", lastS, 1'b1);
        issue(2'b00, 16'h2000);
        drain();
        bitchk("sat_cleared", lastS, 1'b0);

        n0 = ndone;
        issue(2'b00, 16'h2000);
        repeat (3) @(negedge clk);
        start = 1'b1;
        mode  = 2'b11;
        xBus  = 16'h4000;
        @(negedge clk);
        start = 1'b0;
        drain();
        near("busy_ignored", lastR, 16'h1EAF, 2);
        vecs++;
        if (ndone - n0 != 1) begin
            errs++;
            $display("FAIL busy_done_count: got %0d want 1", ndone - n0);
        end

        n0 = ndone;
        issue(2'b01, 16'h3000);
        c0 = cyc;
        while (cyc < c0 + 6) @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        q.delete();
        bitchk("abort_ready", ready, 1'b1);
        bitchk("abort_done", done, 1'b0);
        near("abort_rbus", rBus, 16'h0000, 0);
        bitchk("abort_sat", sat, 1'b0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (20) @(negedge clk);
        vecs++;
        if (ndone != n0) begin
            errs++;
            $display("FAIL abort_no_done: got %0d dones want 0", ndone - n0);
        end
        issue(2'b01, 16'h3000);
        drain();

        for (int i = 0; i < 60; i++) begin
            if (i % 4 == 0) begin
                issue(2'($urandom), edges[$urandom_range(0, 4)]);
            end else begin
                issue(2'($urandom), W'($urandom));
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
